// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter driving a 2:1 mux into a registered valid/ready output stage
//   clk, rst_ (async active-low)
//   req0/in0/gnt0, req1/in1/gnt1 : requester handshakes, gnt high in the cycle the word is taken
//   out_valid/out_data/out_src/out_ready : output word, its source (0 = in0, 1 = in1), consumer accept
module mux_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             req0,
  input  logic [WIDTH-1:0] in0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in1,
  output logic             gnt1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic last;
  logic can_load;
  logic win;
  logic grant;
  always_comb begin
    can_load = (state == EMPTY) | out_ready;
    win      = (req0 & req1) ? !last : req1;
    grant    = rst_ & can_load & (req0 | req1);
    gnt0     = grant & !win;
    gnt1     = grant & win;
  end
  assign out_valid = (state == FULL);
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= EMPTY;
      out_data <= '0;
      out_src  <= 1'b0;
      last     <= 1'b1;
    end else if (grant) begin
      state    <= FULL;
      out_data <= win ? in1 : in0;
      out_src  <= win;
      last     <= win;
    end else if (out_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed self-checking bench for mux_arbiter
module tb_mux_arbiter;
  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       req0 = 1'b0;
  logic [4:0] in0 = '0;
  logic       gnt0;
  logic       req1 = 1'b0;
  logic [4:0] in1 = '0;
  logic       gnt1;
  logic       out_valid;
  logic [4:0] out_data;
  logic       out_src;
  logic       out_ready = 1'b0;
  int total = 0;
  int bad = 0;

  mux_arbiter #(.WIDTH(5)) dut (
    .clk(clk), .rst_(rst_),
    .req0(req0), .in0(in0), .gnt0(gnt0),
    .req1(req1), .in1(in1), .gnt1(gnt1),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_reset();
    rst_ = 1'b0; req0 = 1'b1; in0 = 5'h15; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (gnt0 !== 1'b0) begin bad++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 5'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
    total++; if (out_src !== 1'b0) begin bad++; $display("FAIL reset_src got=%b exp=0", out_src); end
    rst_ = 1'b1;
    #1;
    total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL release_gnt0 got=%b exp=1", gnt0); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL release_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 5'h15) begin bad++; $display("FAIL release_data got=%h exp=15", out_data); end
    total++; if (out_src !== 1'b0) begin bad++; $display("FAIL release_src got=%b exp=0", out_src); end
  endtask

  task automatic test_single();
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b1; in1 = 5'h0A; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin bad++; $display("FAIL single_gnt[%0d] got=%b%b exp=01", i, gnt0, gnt1); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_data !== 5'h0A || out_src !== 1'b1)
        begin bad++; $display("FAIL single_out[%0d] got=%b/%h/%b exp=1/0a/1", i, out_valid, out_data, out_src); end
      @(negedge clk);
    end
    req1 = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [4:0] ed;
    req0 = 1'b1; req1 = 1'b1; in0 = 5'h15; in1 = 5'h0A; out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ed = (i % 2 == 1) ? 5'h0A : 5'h15;
      #1;
      total++; if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1))
        begin bad++; $display("FAIL rr_gnt[%0d] got=%b%b exp=%b%b", i, gnt0, gnt1, i % 2 == 0, i % 2 == 1); end
      @(posedge clk); #1;
      total++; if (out_src !== (i % 2 == 1) || out_data !== ed || out_valid !== 1'b1)
        begin bad++; $display("FAIL rr_out[%0d] got=%b/%h exp=%b/%h", i, out_src, out_data, i % 2 == 1, ed); end
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_backpressure();
    req0 = 1'b1; req1 = 1'b0; in0 = 5'h15; in1 = 5'h0A; out_ready = 1'b1;
    do_reset();
    @(negedge clk);
    total++; if (out_data !== 5'h15 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_load got=%b/%h exp=1/15", out_valid, out_data); end
    req0 = 1'b0; req1 = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (gnt1 !== 1'b0 || gnt0 !== 1'b0) begin bad++; $display("FAIL bp_gnt[%0d] got=%b%b exp=00", i, gnt0, gnt1); end
      @(posedge clk); #1;
      total++; if (out_data !== 5'h15 || out_valid !== 1'b1 || out_src !== 1'b0)
        begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%b exp=1/15/0", i, out_valid, out_data, out_src); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL bp_release_gnt1 got=%b exp=1", gnt1); end
    @(posedge clk); #1;
    total++; if (out_data !== 5'h0A || out_src !== 1'b1 || out_valid !== 1'b1)
      begin bad++; $display("FAIL bp_refill got=%b/%h/%b exp=1/0a/1", out_valid, out_data, out_src); end
  endtask

  task automatic test_drain();
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin bad++; $display("FAIL drain_gnt got=%b%b exp=00", gnt0, gnt1); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || out_data !== 5'h0A || out_src !== 1'b1)
      begin bad++; $display("FAIL drain_out got=%b/%h/%b exp=0/0a/1", out_valid, out_data, out_src); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty_ready got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req0 = 1'b1; in0 = 5'h15; out_ready = 1'b1;
    @(negedge clk);
    req0 = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || out_data !== 5'h15) begin bad++; $display("FAIL mid_full got=%b/%h exp=1/15", out_valid, out_data); end
    req0 = 1'b1; req1 = 1'b1; in1 = 5'h0A;
    #1;
    rst_ = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 5'h00 || out_src !== 1'b0)
      begin bad++; $display("FAIL mid_reset got=%b/%h/%b exp=0/00/0", out_valid, out_data, out_src); end
    total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin bad++; $display("FAIL mid_reset_gnt got=%b%b exp=00", gnt0, gnt1); end
    @(negedge clk);
    rst_ = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin bad++; $display("FAIL mid_first_gnt got=%b%b exp=10", gnt0, gnt1); end
    @(posedge clk); #1;
    total++; if (out_src !== 1'b0 || out_data !== 5'h15 || out_valid !== 1'b1)
      begin bad++; $display("FAIL mid_first_out got=%b/%h/%b exp=1/15/0", out_valid, out_data, out_src); end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
